vdic_serial_alu_n: RTL and testbench



---
 rtl/vdic_alu_pkg.sv | 34 +++
 rtl/vdic_frame_rx.sv | 69 ++++++
 rtl/vdic_serial_alu_n.sv | 206 ++++++++++++++++++++
 tb/tb_vdic_serial_alu_n.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdic_alu_pkg.sv
// Shared definitions for the serial ALU and its bench.
//   operation_t   : 8-bit command opcode
//   FRAME_DATA/CMD: value of the type bit at the head of every frame
//   ST_*          : bit positions inside the status payload
//   is_valid_op   : true for the opcodes the ALU implements
package vdic_alu_pkg;

  typedef enum logic [7:0] {
    OP_NOP = 8'h00,
    OP_AND = 8'h01,
    OP_OR  = 8'h02,
    OP_XOR = 8'h03,
    OP_ADD = 8'h10,
    OP_SUB = 8'h20
  } operation_t;

  localparam logic FRAME_DATA = 1'b0;
  localparam logic FRAME_CMD  = 1'b1;

  localparam int ST_DATA_PAR = 5;
  localparam int ST_CMD_PAR  = 4;
  localparam int ST_BAD_OP   = 3;
  localparam int ST_COUNT    = 2;
  localparam int ST_BORROW   = 1;
  localparam int ST_ZERO     = 0;

  function automatic logic is_valid_op(input logic [7:0] code);
    case (code)
      OP_NOP, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/vdic_frame_rx.sv
// Serial frame deserialiser.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable_n    : low while the sender drives a packet bit on din
//   din         : serial input, MSB (type bit) first
//   listen      : the parent accepts bits this cycle
//   in_pkt      : a packet is in progress (enable_n high between frames aborts too)
//   frame_type  : type bit of the last completed frame
//   payload     : payload of the last completed frame
//   parity_ok   : last completed frame has an odd number of ones
//   frame_done  : one-cycle pulse after the final bit of a frame was sampled
//   abort       : enable_n rose before the packet was complete
module vdic_frame_rx
  import vdic_alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_n,
  input  logic              din,
  input  logic              listen,
  input  logic              in_pkt,
  output logic              frame_type,
  output logic [DATA_W-1:0] payload,
  output logic              parity_ok,
  output logic              frame_done,
  output logic              abort
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  logic [FRAME_W-1:0] frame_sr;
  logic [CNT_W-1:0]   bit_cnt;
  logic               sample;

  assign sample = listen && !enable_n;
  assign abort  = listen && enable_n && (in_pkt || (bit_cnt != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (abort) begin
        bit_cnt <= '0;
      end else if (sample) begin
        if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
          bit_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Frame bits carry no reset; they are only read when frame_done qualifies them.
  always_ff @(posedge clk) begin
    if (sample && !abort)
      frame_sr <= {frame_sr[FRAME_W-2:0], din};
  end

  assign frame_type = frame_sr[FRAME_W-1];
  assign payload    = frame_sr[FRAME_W-2:1];
  assign parity_ok  = ^frame_sr;

endmodule

// File: rtl/vdic_serial_alu_n.sv
// Parametrised serial ALU.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable_n    : low while a packet (data frames + command frame) is on din
//   din         : serial input, MSB first
//   dout        : serial response, MSB first (status frame, then two result frames)
//   dout_valid  : high for every response bit
// All reductions are accumulated in parallel as operands arrive, so the
// command only selects which accumulator becomes the result.
module vdic_serial_alu_n
  import vdic_alu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_OPS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_n,
  input  logic din,
  output logic dout,
  output logic dout_valid
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int RES_W   = 2 * DATA_W;
  localparam int TX_W    = 3 * FRAME_W;
  localparam int TXC_W   = $clog2(TX_W + 1);
  localparam int CNT_W   = $clog2(MAX_OPS + 2);
  localparam logic [CNT_W-1:0] OPS_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0] OPS_MAX = CNT_W'(MAX_OPS);

  typedef enum logic [1:0] {S_IDLE, S_RX, S_CALC, S_TX} state_t;

  state_t state, state_next;

  logic              rx_type, rx_par_ok, rx_done, rx_abort, rx_listen, cmd_done;
  logic [DATA_W-1:0] rx_payload;

  logic [DATA_W-1:0]      acc_and, acc_or, acc_xor;
  logic [RES_W-1:0]       acc_add;
  // One extra sign bit is enough while MAX_OPS <= 2**DATA_W.
  logic signed [RES_W:0]  acc_sub;
  logic signed [RES_W:0]  op_ext;
  logic [CNT_W-1:0]       op_cnt;
  logic                   data_par_err, cmd_par_err;
  logic [DATA_W-1:0]      cmd_payload;

  logic [TX_W-1:0]        tx_sr;
  logic [TXC_W-1:0]       tx_left;

  logic [7:0]             opcode;
  logic                   op_bad, count_bad, has_err, borrow, quiet_nop;
  logic [RES_W-1:0]       result;
  logic [DATA_W-1:0]      status;
  logic [TX_W-1:0]        tx_load;

  function automatic logic [FRAME_W-1:0] make_frame(input logic t, input logic [DATA_W-1:0] p);
    return {t, p, ~(^{t, p})};
  endfunction

  assign cmd_done  = rx_done && (rx_type == FRAME_CMD);
  // The command frame closes the packet: stop listening on the cycle it is consumed.
  assign rx_listen = ((state == S_IDLE) || (state == S_RX)) && !cmd_done;

  vdic_frame_rx #(.DATA_W(DATA_W)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_n   (enable_n),
    .din        (din),
    .listen     (rx_listen),
    .in_pkt     (state == S_RX),
    .frame_type (rx_type),
    .payload    (rx_payload),
    .parity_ok  (rx_par_ok),
    .frame_done (rx_done),
    .abort      (rx_abort)
  );

  assign op_ext = $signed({{(RES_W + 1 - DATA_W){1'b0}}, rx_payload});

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (!enable_n) state_next = S_RX;
      S_RX: begin
        if (rx_abort)      state_next = S_IDLE;
        else if (cmd_done) state_next = S_CALC;
      end
      S_CALC: state_next = quiet_nop ? S_IDLE : S_TX;
      S_TX:   if (tx_left == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    opcode    = cmd_payload[7:0];
    op_bad    = !is_valid_op(opcode) || ((cmd_payload >> 8) != '0);
    count_bad = (op_cnt < OPS_MIN) || (op_cnt > OPS_MAX);
    has_err   = data_par_err || cmd_par_err || op_bad || count_bad;
    result    = '0;
    borrow    = 1'b0;
    case (opcode)
      OP_AND: result = RES_W'(acc_and);
      OP_OR:  result = RES_W'(acc_or);
      OP_XOR: result = RES_W'(acc_xor);
      OP_ADD: result = acc_add;
      OP_SUB: begin
        result = acc_sub[RES_W-1:0];
        borrow = acc_sub[RES_W];
      end
      default: result = '0;
    endcase
    status              = '0;
    status[ST_DATA_PAR] = data_par_err;
    status[ST_CMD_PAR]  = cmd_par_err;
    status[ST_BAD_OP]   = op_bad;
    status[ST_COUNT]    = count_bad;
    if (!has_err) begin
      status[ST_BORROW] = borrow;
      status[ST_ZERO]   = (result == '0);
    end
    quiet_nop = !has_err && (opcode == OP_NOP);
    if (has_err)
      tx_load = {make_frame(FRAME_CMD, status), {(2 * FRAME_W){1'b0}}};
    else
      tx_load = {make_frame(FRAME_CMD, status),
                 make_frame(FRAME_DATA, result[RES_W-1:DATA_W]),
                 make_frame(FRAME_DATA, result[DATA_W-1:0])};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_and      <= '0;
      acc_or       <= '0;
      acc_xor      <= '0;
      acc_add      <= '0;
      acc_sub      <= '0;
      op_cnt       <= '0;
      data_par_err <= 1'b0;
      cmd_par_err  <= 1'b0;
      cmd_payload  <= '0;
      tx_sr        <= '0;
      tx_left      <= '0;
      dout_valid   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!enable_n) begin
            op_cnt       <= '0;
            data_par_err <= 1'b0;
            cmd_par_err  <= 1'b0;
          end
        end
        S_RX: begin
          if (rx_done && !rx_abort) begin
            if (rx_type == FRAME_CMD) begin
              cmd_payload <= rx_payload;
              cmd_par_err <= !rx_par_ok;
            end else begin
              if (!rx_par_ok) data_par_err <= 1'b1;
              // Saturate one above the limit: enough to flag an overflow.
              if (op_cnt <= OPS_MAX) op_cnt <= op_cnt + 1'b1;
              if (op_cnt == '0) begin
                acc_and <= rx_payload;
                acc_or  <= rx_payload;
                acc_xor <= rx_payload;
                acc_add <= RES_W'(rx_payload);
                acc_sub <= op_ext;
              end else if (op_cnt < OPS_MAX) begin
                acc_and <= acc_and & rx_payload;
                acc_or  <= acc_or | rx_payload;
                acc_xor <= acc_xor ^ rx_payload;
                acc_add <= acc_add + RES_W'(rx_payload);
                acc_sub <= acc_sub - op_ext;
              end
            end
          end
        end
        S_CALC: begin
          if (!quiet_nop) begin
            tx_sr      <= tx_load;
            tx_left    <= has_err ? TXC_W'(FRAME_W - 1) : TXC_W'(TX_W - 1);
            dout_valid <= 1'b1;
          end
        end
        S_TX: begin
          if (tx_left == '0) begin
            tx_sr      <= '0;
            dout_valid <= 1'b0;
          end else begin
            tx_sr   <= {tx_sr[TX_W-2:0], 1'b0};
            tx_left <= tx_left - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = tx_sr[TX_W-1];

endmodule

// File: tb/tb_vdic_serial_alu_n.sv
// Bench for vdic_serial_alu_n: directed plan cases plus random packets,
// each checked against an arithmetic reference model.
module tb_vdic_serial_alu_n;
  import vdic_alu_pkg::*;

  localparam int DATA_W  = 8;
  localparam int MAX_OPS = 4;

  logic clk = 1'b0;
  logic rst_n, enable_n, din, dout, dout_valid;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  ops_q[$];
  logic [9:0]  obs_stat_f;
  logic [19:0] obs_res_f;
  int          obs_len;

  always #5 clk = ~clk;

  vdic_serial_alu_n #(.DATA_W(DATA_W), .MAX_OPS(MAX_OPS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_n   (enable_n),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] mk_frame(input logic t, input logic [7:0] p);
    logic par;
    par = (($countones({t, p}) % 2) == 0);
    return {t, p, par};
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    enable_n = 1'b0;
    din      = b;
  endtask

  task automatic send_frame(input logic [9:0] f);
    for (int i = 9; i >= 0; i--) send_bit(f[i]);
  endtask

  task automatic send_packet(input logic [7:0] opc, input int bad);
    logic [9:0] f;
    for (int i = 0; i < ops_q.size(); i++) begin
      f = mk_frame(1'b0, ops_q[i]);
      if (bad == i) f[0] = ~f[0];
      send_frame(f);
    end
    f = mk_frame(1'b1, opc);
    if (bad == ops_q.size()) f[0] = ~f[0];
    send_frame(f);
  endtask

  // Watches at most 80 cycles after the last driven bit; lat counts falling
  // edges after that bit until dout_valid is first seen.
  task automatic collect(output int lat, output int n_bits, output logic [29:0] bits);
    lat    = -1;
    n_bits = 0;
    bits   = '0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 1) begin
        enable_n = 1'b1;
        din      = 1'b0;
      end
      if (dout_valid) begin
        if (lat < 0) lat = c;
        bits = {bits[28:0], dout};
        n_bits++;
      end else if (lat >= 0) begin
        break;
      end
    end
  endtask

  task automatic model(input logic [7:0] opc, input int bad, output int len,
                       output logic [7:0] st, output logic [15:0] res);
    int     n;
    longint acc;
    n   = ops_q.size();
    st  = '0;
    res = '0;
    acc = 0;
    if (bad >= 0 && bad < n) st[ST_DATA_PAR] = 1'b1;
    if (bad == n)            st[ST_CMD_PAR]  = 1'b1;
    if (!(opc inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h20})) st[ST_BAD_OP] = 1'b1;
    if (n < 2 || n > MAX_OPS) st[ST_COUNT] = 1'b1;
    if (st != '0) begin
      len = 10;
    end else if (opc == 8'h00) begin
      len = 0;
    end else begin
      case (opc)
        8'h01: begin acc = 'hFF; for (int i = 0; i < n; i++) acc = acc & ops_q[i]; end
        8'h02: for (int i = 0; i < n; i++) acc = acc | ops_q[i];
        8'h03: for (int i = 0; i < n; i++) acc = acc ^ ops_q[i];
        8'h10: for (int i = 0; i < n; i++) acc = acc + ops_q[i];
        default: begin
          acc = ops_q[0];
          for (int i = 1; i < n; i++) acc = acc - longint'(ops_q[i]);
        end
      endcase
      len = 30;
      res = acc[15:0];
      st[ST_BORROW] = (opc == 8'h20) && (acc < 0);
      st[ST_ZERO]   = (res == 16'h0);
    end
  endtask

  task automatic run_packet(input string tag, input logic [7:0] opc, input int bad);
    int          len, lat, nb;
    logic [7:0]  st;
    logic [15:0] res;
    logic [29:0] bits;
    model(opc, bad, len, st, res);
    send_packet(opc, bad);
    collect(lat, nb, bits);
    obs_len    = nb;
    obs_stat_f = '0;
    obs_res_f  = '0;
    check_eq({tag, ".len"}, nb, len);
    if (len > 0) begin
      check_eq({tag, ".lat"}, lat, 3);
      if (len == 10) begin
        obs_stat_f = bits[9:0];
      end else begin
        obs_stat_f = bits[29:20];
        obs_res_f  = bits[19:0];
        check_eq({tag, ".res"}, obs_res_f, {mk_frame(1'b0, res[15:8]), mk_frame(1'b0, res[7:0])});
      end
      check_eq({tag, ".stat"}, obs_stat_f, mk_frame(1'b1, st));
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, bad, sel, c;
    logic [7:0]  opc;
    int          lat, nb;
    logic [29:0] bits;

    rst_n    = 1'b0;
    enable_n = 1'b1;
    din      = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset.dout", dout, 1'b0);
    check_eq("reset.valid", dout_valid, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    ops_q = '{8'hFF, 8'hFF, 8'h01};
    run_packet("add3", 8'h10, -1);
    check_eq("add3.stat_c", obs_stat_f[8:1], 8'h00);
    check_eq("add3.res_c", {obs_res_f[18:11], obs_res_f[8:1]}, 16'h01FF);
    check_eq("add3.len_c", obs_len, 30);

    ops_q = '{8'h05, 8'h07};
    run_packet("sub", 8'h20, -1);
    check_eq("sub.stat_c", obs_stat_f[8:1], 8'h02);
    check_eq("sub.res_c", {obs_res_f[18:11], obs_res_f[8:1]}, 16'hFFFE);

    ops_q = '{8'hAA, 8'hAA};
    run_packet("xor", 8'h03, -1);
    check_eq("xor.stat_c", obs_stat_f[8:1], 8'h01);
    check_eq("xor.res_c", {obs_res_f[18:11], obs_res_f[8:1]}, 16'h0000);

    ops_q = '{8'hF0, 8'h3C, 8'h0F};
    run_packet("and_par", 8'h01, 1);
    check_eq("and_par.stat_c", obs_stat_f[8:1], 8'h20);
    check_eq("and_par.len_c", obs_len, 10);

    ops_q = '{8'h11, 8'h22};
    run_packet("badop", 8'h07, -1);
    check_eq("badop.stat_c", obs_stat_f[8:1], 8'h08);

    ops_q = '{8'h11, 8'h22};
    run_packet("cmdpar", 8'h02, 2);
    check_eq("cmdpar.stat_c", obs_stat_f[8:1], 8'h10);

    ops_q = '{8'h42};
    run_packet("one_op", 8'h10, -1);
    check_eq("one_op.stat_c", obs_stat_f[8:1], 8'h04);

    ops_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_packet("five_op", 8'h10, -1);
    check_eq("five_op.stat_c", obs_stat_f[8:1], 8'h04);

    ops_q = '{8'h12, 8'h34};
    run_packet("nop", 8'h00, -1);
    check_eq("nop.len_c", obs_len, 0);

    // Abort after 15 bits, then a normal packet must still work.
    send_frame(mk_frame(1'b0, 8'h12));
    for (int i = 9; i >= 5; i--) send_bit(mk_frame(1'b0, 8'h34) >> i);
    collect(lat, nb, bits);
    check_eq("abort.len", nb, 0);
    repeat (2) @(negedge clk);
    ops_q = '{8'h0F, 8'h3C};
    run_packet("after_abort", 8'h01, -1);
    check_eq("after_abort.res_c", {obs_res_f[18:11], obs_res_f[8:1]}, 16'h000C);

    // Reset in the middle of a response.
    ops_q = '{8'h03, 8'h04};
    send_packet(8'h10, -1);
    @(negedge clk);
    enable_n = 1'b1;
    din      = 1'b0;
    c = 0;
    while (!dout_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    check_eq("rst.tx_started", dout_valid, 1'b1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst.valid", dout_valid, 1'b0);
    check_eq("rst.dout", dout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    ops_q = '{8'h21, 8'h13};
    run_packet("after_rst", 8'h10, -1);
    check_eq("after_rst.res_c", {obs_res_f[18:11], obs_res_f[8:1]}, 16'h0034);

    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(1, 5);
      ops_q = {};
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0)
          ops_q.push_back($urandom_range(0, 1) ? 8'hFF : 8'h00);
        else
          ops_q.push_back(8'($urandom_range(0, 255)));
      end
      sel = $urandom_range(0, 9);
      case (sel)
        0:       opc = 8'h00;
        1:       opc = 8'h01;
        2:       opc = 8'h02;
        3:       opc = 8'h03;
        4, 5:    opc = 8'h10;
        6, 7:    opc = 8'h20;
        default: opc = 8'($urandom_range(0, 255));
      endcase
      bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n) : -1;
      run_packet($sformatf("rnd%0d", it), opc, bad);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
